vc_link_arbiter: RTL and testbench
==================================

Name: vc_link_arbiter

Overview:
- Shares one physical output link between NUM_VC virtual-channel buffers (one vc_buffer per VC upstream).
- Allocates the link per packet (wormhole): a head flit wins the link, the grant locks to that VC, and the lock releases only after the tail flit is accepted.
- Flits cross a single output register toward the link. The downstream link handshake is valid/ready.

Parameters:
- NUM_VC, 4, number of VC buffers arbitrated.
- FLIT_W, 34, flit width. Bits [FLIT_W-1:FLIT_W-2] are the flit type.
- VC_ID_W, 2, width of VC index; must equal clog2(NUM_VC).

Ports:
- clk  in  1  clock.
- arst  in  1  reset, synchronous, active-high.
- vc_valid_i  in  NUM_VC  per-VC valid_o from the VC buffers.
- vc_fdata_i  in  NUM_VC*FLIT_W  per-VC flit. VC k occupies bits [k*FLIT_W +: FLIT_W].
- vc_ready_o  out  NUM_VC  per-VC pop strobe, wired to each buffer's ready_i.
- link_valid_o  out  1  output register holds a flit.
- link_fdata_o  out  FLIT_W  output flit.
- link_vc_id_o  out  VC_ID_W  source VC of the output flit.
- link_ready_i  in  1  downstream accepts the flit.
- locked_o  out  1  FSM is in LOCKED.
- grant_o  out  VC_ID_W  currently or last granted VC.
- err_o  out  1  one-cycle pulse on a protocol violation.

Behaviour:
- Flit type encoding, [FLIT_W-1:FLIT_W-2]:
  - 00 = head
  - 01 = body
  - 10 = single (head and tail in one flit)
  - 11 = tail
- Reset (arst=1 at a clk edge):
  - FSM = IDLE, rr_ptr = 0, grant_o = 0.
  - link_valid_o = 0, link_fdata_o = 0, link_vc_id_o = 0.
  - locked_o = 0, err_o = 0.
  - vc_ready_o = 0 combinationally while arst=1.
  - Reset mid-packet abandons the lock. A partially sent packet is not completed.
- Load enable: load = !link_valid_o || link_ready_i. The output register accepts a new flit only when load=1.
- Pop rule: vc_ready_o is one-hot or zero. vc_ready_o[k] = load && sel_valid && (sel == k). A pop and the output-register load occur on the same edge.
- Latency: a flit popped at edge N appears on link_* after edge N. Throughput is 1 flit/cycle with link_ready_i held high.
- IDLE state:
  - Candidates are VCs with vc_valid_i=1.
  - Round-robin search starts at rr_ptr and wraps from NUM_VC-1 to 0. The first candidate found is sel.
  - Winner type 00: pop, load, grant_o = sel, go to LOCKED.
  - Winner type 10: pop, load, rr_ptr = sel+1 (mod NUM_VC), stay IDLE.
  - Winner type 01 or 11: pop and discard (no load), pulse err_o, rr_ptr = sel+1, stay IDLE.
  - If load=0, nothing pops and neither state nor rr_ptr changes.
- LOCKED state:
  - Only VC grant_o is eligible (sel = grant_o, sel_valid = vc_valid_i[grant_o]). All other VCs stall even if valid.
  - Type 01: forward and stay LOCKED.
  - Type 11: forward, go to IDLE, rr_ptr = grant_o+1 (mod NUM_VC).
  - Type 00 or 10: forward, pulse err_o, treat as a tail: go to IDLE, rr_ptr = grant_o+1.
  - Granted VC empty (vc_valid_i low): the lock holds indefinitely. No timeout.
- Backpressure: while link_valid_o=1 and link_ready_i=0, link_* outputs hold stable and no VC pops.
- Simultaneous events: within one edge, a tail accept and the release to IDLE happen together. A new packet may win at the very next edge (zero-bubble).
- Fairness: the VC that just finished has the lowest priority on the next arbitration.
- link_vc_id_o is the registered sel, loaded together with link_fdata_o.

Test Plan:
- Reset then idle: arst=1 for 2 cycles, all vc_valid_i=0 -> link_valid_o=0, vc_ready_o=0, locked_o=0, grant_o=0.
- Single-packet latency: VC2 presents head(00), body(01), tail(11) back-to-back, link_ready_i=1 -> vc_ready_o=4'b0100 for 3 cycles. link_vc_id_o=2 with link_valid_o=1 one cycle later for each flit. locked_o high from after the head until after the tail.
- Lock exclusivity: VC1 packet in flight, VC0 and VC3 offer heads -> no pop on VC0/VC3 until VC1's tail is popped. Next winner is VC3 (rr_ptr=2 after release), then VC0.
- Round-robin of single flits: all 4 VCs continuously offer type 10 -> grant sequence 0,1,2,3,0, one flit/cycle, err_o=0.
- Backpressure: link_ready_i=0 for 3 cycles mid-packet -> link_fdata_o held constant, vc_ready_o=0 in those cycles. Transfer resumes in order, no flit dropped or duplicated.
- Protocol/reset: IDLE winner VC0 offers body(01) -> popped and discarded, err_o pulses once, link_valid_o stays 0. arst asserted while LOCKED -> next cycle locked_o=0, link_valid_o=0, rr_ptr=0.

Source files
------------

// File: rtl/vc_link_arbiter.sv
// Wormhole arbiter: NUM_VC VC buffers share one link, locked per packet, round-robin between packets.
// Latency 1 cycle from pop to link_*; while link_ready_i is low with a flit held, link_* holds and no VC pops.
module vc_link_arbiter #(
  parameter int NUM_VC  = 4,
  parameter int FLIT_W  = 34,
  parameter int VC_ID_W = 2
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic [NUM_VC-1:0]        vc_valid_i,
  input  logic [NUM_VC*FLIT_W-1:0] vc_fdata_i,
  output logic [NUM_VC-1:0]        vc_ready_o,
  output logic                     link_valid_o,
  output logic [FLIT_W-1:0]        link_fdata_o,
  output logic [VC_ID_W-1:0]       link_vc_id_o,
  input  logic                     link_ready_i,
  output logic                     locked_o,
  output logic [VC_ID_W-1:0]       grant_o,
  output logic                     err_o
);

  localparam logic [1:0] TYPE_HEAD   = 2'b00;
  localparam logic [1:0] TYPE_BODY   = 2'b01;
  localparam logic [1:0] TYPE_SINGLE = 2'b10;
  localparam logic [1:0] TYPE_TAIL   = 2'b11;

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t               r_state;
  logic [VC_ID_W-1:0]   r_rr_ptr;
  logic [VC_ID_W-1:0]   r_grant;
  logic                 r_link_valid;
  logic [FLIT_W-1:0]    r_link_fdata;
  logic [VC_ID_W-1:0]   r_link_vc_id;
  logic                 r_err;

  logic                 w_load;
  logic                 w_sel_valid;
  logic                 w_pop;
  logic [VC_ID_W-1:0]   w_rr_sel;
  logic [VC_ID_W-1:0]   w_sel;
  logic [VC_ID_W-1:0]   w_next_ptr;
  logic [VC_ID_W:0]     w_dist;
  logic [VC_ID_W:0]     w_best_dist;
  logic [FLIT_W-1:0]    w_sel_flit;
  logic [1:0]           w_type;

  // Winner is the valid VC with the smallest circular distance from r_rr_ptr.
  always_comb begin
    w_rr_sel    = '0;
    w_dist      = '0;
    w_best_dist = (VC_ID_W+1)'(NUM_VC);
    for (int k = 0; k < NUM_VC; k++) begin
      if (vc_valid_i[k]) begin
        if (k >= int'(r_rr_ptr)) w_dist = (VC_ID_W+1)'(k - int'(r_rr_ptr));
        else                     w_dist = (VC_ID_W+1)'(k + NUM_VC - int'(r_rr_ptr));
        if (w_dist < w_best_dist) begin
          w_best_dist = w_dist;
          w_rr_sel    = VC_ID_W'(k);
        end
      end
    end
  end

  assign w_load      = !r_link_valid || link_ready_i;
  assign w_sel       = (r_state == ST_LOCKED) ? r_grant : w_rr_sel;
  assign w_sel_valid = (r_state == ST_LOCKED) ? vc_valid_i[r_grant] : (|vc_valid_i);
  assign w_pop       = w_load && w_sel_valid && !arst;
  assign w_next_ptr  = (w_sel == VC_ID_W'(NUM_VC-1)) ? '0 : w_sel + 1'b1;
  assign w_type      = w_sel_flit[FLIT_W-1 -: 2];

  always_comb begin
    w_sel_flit = '0;
    vc_ready_o = '0;
    for (int k = 0; k < NUM_VC; k++) begin
      if (w_sel == VC_ID_W'(k)) w_sel_flit = vc_fdata_i[k*FLIT_W +: FLIT_W];
      vc_ready_o[k] = w_pop && (w_sel == VC_ID_W'(k));
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      r_state      <= ST_IDLE;
      r_rr_ptr     <= '0;
      r_grant      <= '0;
      r_link_valid <= 1'b0;
      r_link_fdata <= '0;
      r_link_vc_id <= '0;
      r_err        <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (w_load) r_link_valid <= 1'b0;
      if (w_pop) begin
        case (r_state)
          ST_IDLE: begin
            case (w_type)
              TYPE_HEAD: begin
                r_link_valid <= 1'b1;
                r_link_fdata <= w_sel_flit;
                r_link_vc_id <= w_sel;
                r_grant      <= w_sel;
                r_state      <= ST_LOCKED;
              end
              TYPE_SINGLE: begin
                r_link_valid <= 1'b1;
                r_link_fdata <= w_sel_flit;
                r_link_vc_id <= w_sel;
                r_rr_ptr     <= w_next_ptr;
              end
              default: begin
                // Orphan body/tail with no packet open: drop it and flag.
                r_err    <= 1'b1;
                r_rr_ptr <= w_next_ptr;
              end
            endcase
          end
          ST_LOCKED: begin
            r_link_valid <= 1'b1;
            r_link_fdata <= w_sel_flit;
            r_link_vc_id <= w_sel;
            if (w_type != TYPE_BODY) begin
              // A head or single inside a packet is flagged and closes the packet like a tail.
              r_state  <= ST_IDLE;
              r_rr_ptr <= w_next_ptr;
              r_err    <= (w_type != TYPE_TAIL);
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign link_valid_o = r_link_valid;
  assign link_fdata_o = r_link_fdata;
  assign link_vc_id_o = r_link_vc_id;
  assign locked_o     = (r_state == ST_LOCKED);
  assign grant_o      = r_grant;
  assign err_o        = r_err;

endmodule

// File: tb/tb_vc_link_arbiter.sv
// Bench for vc_link_arbiter: directed scenarios plus a randomized run against a packet-level reference model.
module tb_vc_link_arbiter;

  localparam int NV = 4;
  localparam int FW = 34;

  logic            clk = 1'b0;
  logic            arst = 1'b1;
  logic [NV-1:0]   vc_valid = '0;
  logic [NV*FW-1:0] vc_fdata = '0;
  logic [NV-1:0]   vc_ready;
  logic            link_valid;
  logic [FW-1:0]   link_fdata;
  logic [1:0]      link_vc_id;
  logic            link_ready = 1'b1;
  logic            locked;
  logic [1:0]      grant;
  logic            err;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: open packet owner, arbitration pointer, link register.
  int          m_locked = 0, m_owner = 0, m_rr = 0, m_lv = 0, m_lid = 0, m_err = 0;
  logic [FW-1:0] m_ld = '0;

  vc_link_arbiter dut (
    .clk          (clk),
    .arst         (arst),
    .vc_valid_i   (vc_valid),
    .vc_fdata_i   (vc_fdata),
    .vc_ready_o   (vc_ready),
    .link_valid_o (link_valid),
    .link_fdata_o (link_fdata),
    .link_vc_id_o (link_vc_id),
    .link_ready_i (link_ready),
    .locked_o     (locked),
    .grant_o      (grant),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  function automatic int m_pick();
    if (m_locked != 0) return vc_valid[m_owner] ? m_owner : -1;
    for (int i = 0; i < NV; i++)
      if (vc_valid[(m_rr + i) % NV]) return (m_rr + i) % NV;
    return -1;
  endfunction

  function automatic logic [NV-1:0] m_ready();
    int k;
    k = m_pick();
    if (arst || k < 0 || !(m_lv == 0 || link_ready)) return '0;
    return NV'(1 << k);
  endfunction

  task automatic model_edge();
    int k;
    logic [FW-1:0] f;
    logic [1:0] t;
    if (arst) begin
      m_locked = 0; m_owner = 0; m_rr = 0; m_lv = 0; m_lid = 0; m_err = 0; m_ld = '0;
      return;
    end
    m_err = 0;
    if (!(m_lv == 0 || link_ready)) return;
    k = m_pick();
    m_lv = 0;
    if (k < 0) return;
    f = vc_fdata[k*FW +: FW];
    t = f[FW-1 -: 2];
    if (m_locked == 0) begin
      if (t == 2'b00 || t == 2'b10) begin
        m_lv = 1; m_ld = f; m_lid = k;
        if (t == 2'b00) begin m_locked = 1; m_owner = k; end
        else m_rr = (k + 1) % NV;
      end else begin
        m_err = 1; m_rr = (k + 1) % NV;
      end
    end else begin
      m_lv = 1; m_ld = f; m_lid = k;
      if (t != 2'b01) begin
        m_locked = 0; m_rr = (k + 1) % NV;
        m_err = (t == 2'b00 || t == 2'b10) ? 1 : 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_vc(input int k, input logic v, input logic [1:0] t, input logic [31:0] p);
    vc_valid[k] = v;
    vc_fdata[k*FW +: FW] = {t, p};
  endtask

  task automatic clear_vcs();
    vc_valid = '0;
  endtask

  task automatic test_reset();
    arst = 1'b1; clear_vcs(); link_ready = 1'b1;
    tick(); tick();
    n_vec++; if (link_valid !== 1'b0) begin n_err++; $display("FAIL reset_link_valid got=%b want=0", link_valid); end
    n_vec++; if (vc_ready !== 4'b0000) begin n_err++; $display("FAIL reset_vc_ready got=%b want=0000", vc_ready); end
    n_vec++; if (locked !== 1'b0 || err !== 1'b0) begin n_err++; $display("FAIL reset_locked_err got=%b%b want=00", locked, err); end
    n_vec++; if (grant !== 2'd0 || link_vc_id !== 2'd0 || link_fdata !== '0) begin n_err++; $display("FAIL reset_regs grant=%0d id=%0d data=%h want=0", grant, link_vc_id, link_fdata); end
    for (int k = 0; k < NV; k++) set_vc(k, 1'b1, 2'b10, 32'h0);
    #1;
    n_vec++; if (vc_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready_gated got=%b want=0000", vc_ready); end
    clear_vcs();
    arst = 1'b0;
    tick();
  endtask

  task automatic test_single_packet();
    logic [1:0]  types [3];
    logic [31:0] pl;
    types[0] = 2'b00; types[1] = 2'b01; types[2] = 2'b11;
    for (int i = 0; i < 3; i++) begin
      pl = 32'hA200_0000 + 32'(i);
      set_vc(2, 1'b1, types[i], pl);
      #1;
      n_vec++; if (vc_ready !== 4'b0100) begin n_err++; $display("FAIL single_pop%0d got=%b want=0100", i, vc_ready); end
      tick();
      n_vec++; if (link_valid !== 1'b1 || link_vc_id !== 2'd2 || link_fdata !== {types[i], pl})
        begin n_err++; $display("FAIL single_out%0d v=%b id=%0d data=%h want v=1 id=2 data=%h", i, link_valid, link_vc_id, link_fdata, {types[i], pl}); end
      n_vec++; if (locked !== (i < 2)) begin n_err++; $display("FAIL single_locked%0d got=%b want=%b", i, locked, (i < 2)); end
    end
    clear_vcs();
    tick();
    n_vec++; if (link_valid !== 1'b0) begin n_err++; $display("FAIL single_drain got=%b want=0", link_valid); end
  endtask

  task automatic test_lock_exclusivity();
    // Pointer sits at 3 after the VC2 packet; VC1 opens a packet alone first.
    set_vc(1, 1'b1, 2'b00, 32'h1100);
    #1;
    n_vec++; if (vc_ready !== 4'b0010) begin n_err++; $display("FAIL excl_head got=%b want=0010", vc_ready); end
    tick();
    n_vec++; if (locked !== 1'b1 || grant !== 2'd1) begin n_err++; $display("FAIL excl_grant locked=%b grant=%0d want 1/1", locked, grant); end
    set_vc(0, 1'b1, 2'b00, 32'h0000); set_vc(3, 1'b1, 2'b00, 32'h3300);
    set_vc(1, 1'b1, 2'b01, 32'h1101);
    #1;
    n_vec++; if (vc_ready !== 4'b0010) begin n_err++; $display("FAIL excl_body got=%b want=0010", vc_ready); end
    tick();
    set_vc(1, 1'b1, 2'b11, 32'h1102);
    #1;
    n_vec++; if (vc_ready !== 4'b0010) begin n_err++; $display("FAIL excl_tail got=%b want=0010", vc_ready); end
    tick();
    n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL excl_release got=%b want=0", locked); end
    set_vc(1, 1'b0, 2'b00, 32'h0);
    #1;
    n_vec++; if (vc_ready !== 4'b1000) begin n_err++; $display("FAIL excl_next_vc3 got=%b want=1000", vc_ready); end
    tick();
    set_vc(3, 1'b1, 2'b11, 32'h3301);
    #1;
    n_vec++; if (vc_ready !== 4'b1000) begin n_err++; $display("FAIL excl_vc3_tail got=%b want=1000", vc_ready); end
    tick();
    set_vc(3, 1'b0, 2'b00, 32'h0);
    #1;
    n_vec++; if (vc_ready !== 4'b0001) begin n_err++; $display("FAIL excl_next_vc0 got=%b want=0001", vc_ready); end
    tick();
    set_vc(0, 1'b1, 2'b11, 32'h0001);
    tick();
    clear_vcs();
    tick();
  endtask

  task automatic test_round_robin();
    arst = 1'b1; tick(); arst = 1'b0;
    for (int k = 0; k < NV; k++) set_vc(k, 1'b1, 2'b10, 32'h5000 + 32'(k));
    for (int i = 0; i < 5; i++) begin
      #1;
      n_vec++; if (vc_ready !== 4'(1 << (i % NV))) begin n_err++; $display("FAIL rr_pop%0d got=%b want=%b", i, vc_ready, 4'(1 << (i % NV))); end
      tick();
      n_vec++; if (link_valid !== 1'b1 || link_vc_id !== 2'(i % NV) || err !== 1'b0)
        begin n_err++; $display("FAIL rr_out%0d v=%b id=%0d err=%b want v=1 id=%0d err=0", i, link_valid, link_vc_id, err, i % NV); end
    end
    clear_vcs();
    tick();
  endtask

  task automatic test_backpressure();
    // Pointer is at 1 after five singles.
    link_ready = 1'b1;
    set_vc(1, 1'b1, 2'b00, 32'hB000);
    tick();
    set_vc(1, 1'b1, 2'b01, 32'hB001);
    tick();
    link_ready = 1'b0;
    set_vc(1, 1'b1, 2'b01, 32'hB002);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++; if (vc_ready !== 4'b0000) begin n_err++; $display("FAIL bp_stall%0d got=%b want=0000", i, vc_ready); end
      tick();
      n_vec++; if (link_valid !== 1'b1 || link_fdata !== {2'b01, 32'hB001})
        begin n_err++; $display("FAIL bp_hold%0d v=%b data=%h want v=1 data=%h", i, link_valid, link_fdata, {2'b01, 32'hB001}); end
    end
    link_ready = 1'b1;
    #1;
    n_vec++; if (vc_ready !== 4'b0010) begin n_err++; $display("FAIL bp_resume got=%b want=0010", vc_ready); end
    tick();
    n_vec++; if (link_fdata !== {2'b01, 32'hB002}) begin n_err++; $display("FAIL bp_next got=%h want=%h", link_fdata, {2'b01, 32'hB002}); end
    set_vc(1, 1'b1, 2'b11, 32'hB003);
    tick();
    n_vec++; if (link_fdata !== {2'b11, 32'hB003} || locked !== 1'b0)
      begin n_err++; $display("FAIL bp_tail data=%h locked=%b want data=%h locked=0", link_fdata, locked, {2'b11, 32'hB003}); end
    clear_vcs();
    tick();
  endtask

  task automatic test_protocol_reset();
    arst = 1'b1; tick(); arst = 1'b0;
    set_vc(0, 1'b1, 2'b01, 32'hDEAD);
    #1;
    n_vec++; if (vc_ready !== 4'b0001) begin n_err++; $display("FAIL proto_pop got=%b want=0001", vc_ready); end
    tick();
    n_vec++; if (err !== 1'b1 || link_valid !== 1'b0) begin n_err++; $display("FAIL proto_err err=%b v=%b want err=1 v=0", err, link_valid); end
    clear_vcs();
    tick();
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL proto_err_pulse got=%b want=0", err); end
    set_vc(2, 1'b1, 2'b00, 32'hC000);
    tick();
    n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL proto_lock got=%b want=1", locked); end
    arst = 1'b1;
    tick();
    n_vec++; if (locked !== 1'b0 || link_valid !== 1'b0) begin n_err++; $display("FAIL proto_rst locked=%b v=%b want 0/0", locked, link_valid); end
    arst = 1'b0;
    clear_vcs();
    set_vc(0, 1'b1, 2'b10, 32'hC100); set_vc(1, 1'b1, 2'b10, 32'hC101);
    #1;
    n_vec++; if (vc_ready !== 4'b0001) begin n_err++; $display("FAIL proto_rr_reset got=%b want=0001", vc_ready); end
    tick();
    clear_vcs();
    tick();
  endtask

  task automatic test_random();
    arst = 1'b1; tick(); arst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      arst = ($urandom_range(0, 99) == 0);
      link_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < NV; k++)
        set_vc(k, 1'($urandom_range(0, 2) != 0), 2'($urandom_range(0, 3)), $urandom);
      #1;
      n_vec++; if (vc_ready !== m_ready()) begin n_err++; $display("FAIL rnd_ready c=%0d got=%b want=%b", c, vc_ready, m_ready()); end
      tick();
      n_vec++; if (link_valid !== 1'(m_lv) || link_vc_id !== 2'(m_lid) || link_fdata !== m_ld)
        begin n_err++; $display("FAIL rnd_link c=%0d v=%b id=%0d data=%h want v=%0d id=%0d data=%h", c, link_valid, link_vc_id, link_fdata, m_lv, m_lid, m_ld); end
      n_vec++; if (locked !== 1'(m_locked) || grant !== 2'(m_owner) || err !== 1'(m_err))
        begin n_err++; $display("FAIL rnd_ctrl c=%0d locked=%b grant=%0d err=%b want %0d/%0d/%0d", c, locked, grant, err, m_locked, m_owner, m_err); end
    end
    arst = 1'b0;
    link_ready = 1'b1;
    clear_vcs();
    tick();
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_lock_exclusivity();
    test_round_robin();
    test_backpressure();
    test_protocol_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
